// File: rtl/timer_testbench_pkg.sv
// rtl/timer_testbench_pkg.sv - register map, bit positions and clock-select encodings for the timer
package timer_testbench_pkg;

    localparam logic [7:0] ADDR_TDR  = 8'h00;
    localparam logic [7:0] ADDR_TCR  = 8'h01;
    localparam logic [7:0] ADDR_TSR  = 8'h02;
    localparam logic [7:0] ADDR_TCNT = 8'h03;

    localparam int TCR_LOAD = 7;
    localparam int TCR_DOWN = 5;
    localparam int TCR_EN   = 4;
    localparam logic [7:0] TCR_MASK = 8'hB3;

    localparam int TSR_OVF = 0;
    localparam int TSR_UDF = 1;
    localparam logic [7:0] TSR_MASK = 8'h03;

    typedef enum logic [1:0] {
        CKS_DIV2  = 2'b00,
        CKS_DIV4  = 2'b01,
        CKS_DIV8  = 2'b10,
        CKS_DIV16 = 2'b11
    } cks_t;

endpackage

// File: rtl/timer_prescaler.sv
// rtl/timer_prescaler.sv - free-running 4-bit divider with CKS-selected one-cycle tick
module timer_prescaler
    import timer_testbench_pkg::*;
(
    input  logic       pclk,
    input  logic       presetn,
    input  logic [1:0] cks,
    output logic       tick
);

    logic [3:0] div;

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            div <= 4'd0;
        end else begin
            div <= div + 4'd1;
        end
    end

    // Tick fires when the low bits of the divider are all ones, giving a 2/4/8/16 cycle period.
    always_comb begin
        tick = 1'b0;
        case (cks)
            CKS_DIV2:  tick = div[0];
            CKS_DIV4:  tick = &div[1:0];
            CKS_DIV8:  tick = &div[2:0];
            CKS_DIV16: tick = &div;
            default:   tick = 1'b0;
        endcase
    end

endmodule

// File: rtl/timer_testbench.sv
// rtl/timer_testbench.sv - APB-programmable 8-bit up/down timer with sticky overflow/underflow flags
module timer_testbench
    import timer_testbench_pkg::*;
(
    input  logic       pclk,
    input  logic       presetn,
    input  logic       psel,
    input  logic       penable,
    input  logic       pwrite,
    input  logic [7:0] paddr,
    input  logic [7:0] pwdata,
    output logic [7:0] prdata,
    output logic       pready,
    output logic       pslverr,
    output logic       tmr_ovf,
    output logic       tmr_udf
);

    logic [7:0] tdr;
    logic [7:0] tcr;
    logic [7:0] tsr;
    logic [7:0] tcnt;
    logic [7:0] tsr_kept;
    logic [7:0] tsr_set;
    logic       tick;
    logic       wr_en;
    logic       rd_en;
    logic       cnt_step;

    timer_prescaler u_prescaler (
        .pclk    (pclk),
        .presetn (presetn),
        .cks     (tcr[1:0]),
        .tick    (tick)
    );

    assign wr_en    = psel & penable & pwrite;
    assign rd_en    = psel & penable & ~pwrite;
    assign cnt_step = ~tcr[TCR_LOAD] & tcr[TCR_EN] & tick;

    // Software clear is an AND mask; hardware set is ORed afterwards so a coincident set wins.
    always_comb begin
        tsr_set          = 8'h00;
        tsr_set[TSR_OVF] = cnt_step & ~tcr[TCR_DOWN] & (tcnt == 8'hFF);
        tsr_set[TSR_UDF] = cnt_step &  tcr[TCR_DOWN] & (tcnt == 8'h00);
        tsr_kept         = tsr;
        if (wr_en && (paddr == ADDR_TSR)) begin
            tsr_kept = tsr & pwdata;
        end
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            tdr  <= 8'h00;
            tcr  <= 8'h00;
            tsr  <= 8'h00;
            tcnt <= 8'h00;
        end else begin
            if (wr_en && (paddr == ADDR_TDR)) begin
                tdr <= pwdata;
            end
            if (wr_en && (paddr == ADDR_TCR)) begin
                tcr <= pwdata & TCR_MASK;
            end
            tsr <= (tsr_kept | tsr_set) & TSR_MASK;
            if (tcr[TCR_LOAD]) begin
                tcnt <= tdr;
            end else if (cnt_step) begin
                tcnt <= tcr[TCR_DOWN] ? (tcnt - 8'd1) : (tcnt + 8'd1);
            end
        end
    end

    always_comb begin
        prdata = 8'h00;
        if (rd_en) begin
            case (paddr)
                ADDR_TDR:  prdata = tdr;
                ADDR_TCR:  prdata = tcr;
                ADDR_TSR:  prdata = tsr;
                ADDR_TCNT: prdata = tcnt;
                default:   prdata = 8'h00;
            endcase
        end
    end

    assign pready  = 1'b1;
    assign pslverr = psel & penable & (paddr > ADDR_TCNT);
    assign tmr_ovf = tsr[TSR_OVF];
    assign tmr_udf = tsr[TSR_UDF];

endmodule

// File: tb/tb_timer_testbench.sv
// tb/tb_timer_testbench.sv - scoreboard bench for the APB timer
module tb_timer_testbench;

    logic       pclk;
    logic       presetn;
    logic       psel;
    logic       penable;
    logic       pwrite;
    logic [7:0] paddr;
    logic [7:0] pwdata;
    logic [7:0] prdata;
    logic       pready;
    logic       pslverr;
    logic       tmr_ovf;
    logic       tmr_udf;

    int checks;
    int errors;

    typedef struct {
        string      name;
        logic [7:0] data;
        logic       err;
    } exp_t;

    exp_t exp_q[$];

    timer_testbench dut (
        .pclk    (pclk),
        .presetn (presetn),
        .psel    (psel),
        .penable (penable),
        .pwrite  (pwrite),
        .paddr   (paddr),
        .pwdata  (pwdata),
        .prdata  (prdata),
        .pready  (pready),
        .pslverr (pslverr),
        .tmr_ovf (tmr_ovf),
        .tmr_udf (tmr_udf)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    task automatic apb_write(input logic [7:0] addr, input logic [7:0] data);
        @(negedge pclk);
        psel = 1'b1; pwrite = 1'b1; penable = 1'b0; paddr = addr; pwdata = data;
        @(negedge pclk);
        penable = 1'b1;
        @(negedge pclk);
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic apb_read(input string name, input logic [7:0] addr,
                            input logic [7:0] data, input logic err);
        exp_t e;
        e.name = name; e.data = data; e.err = err;
        exp_q.push_back(e);
        @(negedge pclk);
        psel = 1'b1; pwrite = 1'b0; penable = 1'b0; paddr = addr;
        @(negedge pclk);
        penable = 1'b1;
        @(negedge pclk);
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge pclk);
    endtask

    // Monitor: every read access phase pops one expectation and compares data and error.
    always @(negedge pclk) begin
        #1;
        if (psel && penable && !pwrite) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_read: addr %h prdata %h with no expectation", paddr, prdata);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (prdata !== e.data || pslverr !== e.err || pready !== 1'b1) begin
                    errors++;
                    $display("FAIL %s: got prdata %h pslverr %b pready %b expected prdata %h pslverr %b pready 1",
                             e.name, prdata, pslverr, pready, e.data, e.err);
                end
            end
        end
    end

    initial begin
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = 8'h00; pwdata = 8'h00;
        checks = 0; errors = 0;
        presetn = 1'b0;
        wait_cycles(3);
        check_bit("reset_ovf", tmr_ovf, 1'b0);
        check_bit("reset_udf", tmr_udf, 1'b0);
        check_bit("reset_pslverr", pslverr, 1'b0);
        presetn = 1'b1;
        apb_read("reset_tdr", 8'h00, 8'h00, 1'b0);
        apb_read("reset_tcr", 8'h01, 8'h00, 1'b0);
        apb_read("reset_tsr", 8'h02, 8'h00, 1'b0);
        apb_read("reset_tcnt", 8'h03, 8'h00, 1'b0);

        // Down count from 0xFF at /2: underflow lands 511..512 pclk after enable.
        apb_write(8'h00, 8'hFF);
        apb_write(8'h01, 8'h80);
        apb_write(8'h01, 8'h30);
        wait_cycles(496);
        apb_read("down_tsr_500", 8'h02, 8'h00, 1'b0);
        wait_cycles(20);
        apb_read("down_tsr_520", 8'h02, 8'h02, 1'b0);
        check_bit("down_udf_out", tmr_udf, 1'b1);
        check_bit("down_ovf_out", tmr_ovf, 1'b0);
        apb_write(8'h02, 8'h00);
        apb_read("down_tsr_cleared", 8'h02, 8'h00, 1'b0);
        apb_write(8'h01, 8'h00);

        // Up count from 0x00 at /2: overflow after 256 ticks.
        apb_write(8'h00, 8'h00);
        apb_write(8'h01, 8'h80);
        apb_write(8'h01, 8'h10);
        wait_cycles(520);
        apb_read("up_tsr_520", 8'h02, 8'h01, 1'b0);
        check_bit("up_ovf_out", tmr_ovf, 1'b1);
        check_bit("up_udf_out", tmr_udf, 1'b0);

        // Asynchronous reset mid-count with OVF already set.
        apb_write(8'h00, 8'h33);
        apb_write(8'h01, 8'h11);
        wait_cycles(20);
        #2 presetn = 1'b0;
        #1;
        check_bit("rst_ovf_out", tmr_ovf, 1'b0);
        check_bit("rst_udf_out", tmr_udf, 1'b0);
        wait_cycles(2);
        presetn = 1'b1;
        apb_read("rst_tdr", 8'h00, 8'h00, 1'b0);
        apb_read("rst_tcr", 8'h01, 8'h00, 1'b0);
        apb_read("rst_tsr", 8'h02, 8'h00, 1'b0);
        apb_read("rst_tcnt", 8'h03, 8'h00, 1'b0);

        // CKS=11 from 0xF0: 16 ticks of 16 pclk, overflow between 241 and 256 pclk.
        apb_write(8'h00, 8'hF0);
        apb_write(8'h01, 8'h80);
        apb_write(8'h01, 8'h13);
        wait_cycles(230);
        apb_read("cks3_tsr_232", 8'h02, 8'h00, 1'b0);
        wait_cycles(30);
        apb_read("cks3_tsr_264", 8'h02, 8'h01, 1'b0);
        apb_read("cks3_tcr", 8'h01, 8'h13, 1'b0);
        apb_write(8'h02, 8'hFE);
        apb_read("cks3_tsr_clr", 8'h02, 8'h00, 1'b0);
        apb_write(8'h01, 8'h00);

        // LOAD held (with EN/DOWN also set) keeps TCNT at TDR; EN=0 then freezes it.
        apb_write(8'h00, 8'h5A);
        apb_write(8'h01, 8'hFF);
        apb_read("load_tcr_mask", 8'h01, 8'hB3, 1'b0);
        wait_cycles(10);
        apb_read("load_tcnt_a", 8'h03, 8'h5A, 1'b0);
        wait_cycles(40);
        apb_read("load_tcnt_b", 8'h03, 8'h5A, 1'b0);
        apb_write(8'h01, 8'h00);
        wait_cycles(50);
        apb_read("freeze_tcnt", 8'h03, 8'h5A, 1'b0);

        // Writing ones to TSR cannot set flags; out-of-range addresses error and read zero.
        apb_write(8'h02, 8'hFF);
        apb_read("tsr_ones", 8'h02, 8'h00, 1'b0);
        apb_write(8'h07, 8'hFF);
        apb_read("bad_07", 8'h07, 8'h00, 1'b1);
        apb_read("bad_04", 8'h04, 8'h00, 1'b1);
        apb_read("tdr_after_bad", 8'h00, 8'h5A, 1'b0);
        apb_write(8'h03, 8'h11);
        apb_read("tcnt_readonly", 8'h03, 8'h5A, 1'b0);

        for (int i = 0; i < 100 && exp_q.size() != 0; i++) begin
            @(negedge pclk);
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain: %0d reads pending expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
